// File: rtl/controle_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes,
// funct codes, ULA operations, cause codes and datapath mux selects.
package controle_pkg;

  typedef enum logic [4:0] {
    S_RESET      = 5'd0,
    S_FETCH      = 5'd1,
    S_FETCH_WAIT = 5'd2,
    S_DECODE     = 5'd3,
    S_R_EXEC     = 5'd4,
    S_R_WB       = 5'd5,
    S_ADDI_EXEC  = 5'd6,
    S_ADDI_WB    = 5'd7,
    S_MEM_ADDR   = 5'd8,
    S_LW_READ    = 5'd9,
    S_LW_WAIT    = 5'd10,
    S_LW_WB      = 5'd11,
    S_SW_WRITE   = 5'd12,
    S_BRANCH     = 5'd13,
    S_JUMP       = 5'd14,
    S_EXC_EPC    = 5'd15,
    S_EXC_JUMP   = 5'd16,
    S_HALT       = 5'd17
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_BREAK = 6'h0D;

  localparam logic [2:0] ULA_ADD = 3'b001;
  localparam logic [2:0] ULA_SUB = 3'b010;
  localparam logic [2:0] ULA_AND = 3'b011;
  localparam logic [2:0] ULA_XOR = 3'b110;

  localparam logic [1:0] CAUSE_INV = 2'b00;
  localparam logic [1:0] CAUSE_OVF = 2'b01;

  localparam logic [1:0] PCSRC_ULA    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_EXC    = 2'b11;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_SEXT    = 2'b10;
  localparam logic [1:0] SRCB_SEXT_SH = 2'b11;

  function automatic logic is_r_supported(input logic [5:0] fn);
    case (fn)
      FN_ADD, FN_SUB, FN_AND, FN_XOR: is_r_supported = 1'b1;
      default:                        is_r_supported = 1'b0;
    endcase
  endfunction

  function automatic logic is_add_sub(input logic [5:0] fn);
    is_add_sub = (fn == FN_ADD) || (fn == FN_SUB);
  endfunction

  function automatic logic [2:0] r_ula_op(input logic [5:0] fn);
    case (fn)
      FN_SUB:  r_ula_op = ULA_SUB;
      FN_AND:  r_ula_op = ULA_AND;
      FN_XOR:  r_ula_op = ULA_XOR;
      default: r_ula_op = ULA_ADD;
    endcase
  endfunction

endpackage

// File: rtl/controle_multiciclo_exc_if.sv
// Control bus between the multicycle controller (master) and the MIPS
// datapath (slave): IR fields and ULA flags in, enables and selects out.
interface controle_multiciclo_exc_if #(
  parameter int STATE_W = 5
);
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               ula_zero;
  logic               ula_overflow;
  logic               rst_out;
  logic               pc_write;
  logic [1:0]         pc_source;
  logic               iord;
  logic               mem_wr;
  logic               ir_write;
  logic               mdr_write;
  logic               a_write;
  logic               b_write;
  logic               alu_out_write;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               reg_write;
  logic               ula_src_a;
  logic [1:0]         ula_src_b;
  logic [2:0]         ula_op;
  logic               epc_write;
  logic               cause_write;
  logic [1:0]         cause;
  logic [STATE_W-1:0] estado;

  modport master (
    input  opcode, funct, ula_zero, ula_overflow,
    output rst_out, pc_write, pc_source, iord, mem_wr, ir_write, mdr_write,
           a_write, b_write, alu_out_write, reg_dst, mem_to_reg, reg_write,
           ula_src_a, ula_src_b, ula_op, epc_write, cause_write, cause, estado
  );

  modport slave (
    output opcode, funct, ula_zero, ula_overflow,
    input  rst_out, pc_write, pc_source, iord, mem_wr, ir_write, mdr_write,
           a_write, b_write, alu_out_write, reg_dst, mem_to_reg, reg_write,
           ula_src_a, ula_src_b, ula_op, epc_write, cause_write, cause, estado
  );
endinterface

// File: rtl/controle_wait_cnt.sv
// Memory wait-state down-counter: load presets MEM_WAIT-1, done flags zero.
module controle_wait_cnt #(
  parameter int MEM_WAIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic done
);
  localparam logic [2:0] LOAD_VAL = (MEM_WAIT > 0) ? 3'(MEM_WAIT - 1) : 3'd0;

  logic [2:0] cnt_r;

  // Count down toward zero after each load and hold there.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= 3'd0;
    end else if (load) begin
      cnt_r <= LOAD_VAL;
    end else if (cnt_r != 3'd0) begin
      cnt_r <= cnt_r - 3'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = (cnt_r == 3'd0);

endmodule

// File: rtl/controle_multiciclo_exc.sv
// Multicycle MIPS control FSM with memory wait states and precise exceptions.
// Define CONTROLE_EXC_EN to enable EPC/Cause exception sequencing.
module controle_multiciclo_exc
  import controle_pkg::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int STATE_W  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  controle_multiciclo_exc_if.master bus
);

`ifdef CONTROLE_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif
  localparam bit     NO_WAIT  = (MEM_WAIT == 0);
  localparam state_t INV_NEXT = EXC_EN ? S_EXC_EPC : S_FETCH;

  state_t state_r;
  state_t state_next_s;
  logic   wait_load_s;
  logic   wait_done_s;
  logic   fetch_done_s;

  controle_wait_cnt #(.MEM_WAIT(MEM_WAIT)) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (wait_load_s),
    .done  (wait_done_s)
  );

  assign wait_load_s = ((state_r == S_FETCH)   && (state_next_s == S_FETCH_WAIT)) ||
                       ((state_r == S_LW_READ) && (state_next_s == S_LW_WAIT));
  assign fetch_done_s = ((state_r == S_FETCH) && NO_WAIT) ||
                        ((state_r == S_FETCH_WAIT) && wait_done_s);
  assign bus.estado = STATE_W'(state_r);

  // State register; reset wins over any in-flight instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_RESET;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    state_next_s      = state_r;
    bus.rst_out       = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_source     = PCSRC_ULA;
    bus.iord          = 1'b0;
    bus.mem_wr        = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mdr_write     = 1'b0;
    bus.a_write       = 1'b0;
    bus.b_write       = 1'b0;
    bus.alu_out_write = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_write     = 1'b0;
    bus.ula_src_a     = 1'b0;
    bus.ula_src_b     = SRCB_B;
    bus.ula_op        = 3'b000;
    case (state_r)
      S_RESET: begin
        bus.rst_out  = 1'b1;
        state_next_s = S_FETCH;
      end
      S_FETCH, S_FETCH_WAIT: begin
        if (fetch_done_s) begin
          bus.ir_write  = 1'b1;
          bus.pc_write  = 1'b1;
          bus.ula_src_b = SRCB_FOUR;
          bus.ula_op    = ULA_ADD;
          state_next_s  = S_DECODE;
        end else begin
          state_next_s  = S_FETCH_WAIT;
        end
      end
      S_DECODE: begin
        bus.a_write       = 1'b1;
        bus.b_write       = 1'b1;
        bus.alu_out_write = 1'b1;
        bus.ula_src_b     = SRCB_SEXT_SH;
        bus.ula_op        = ULA_ADD;
        case (bus.opcode)
          OP_R: begin
            if (bus.funct == FN_BREAK) begin
              state_next_s = S_HALT;
            end else if (is_r_supported(bus.funct)) begin
              state_next_s = S_R_EXEC;
            end else begin
              state_next_s = INV_NEXT;
            end
          end
          OP_ADDI:        state_next_s = S_ADDI_EXEC;
          OP_LW, OP_SW:   state_next_s = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_next_s = S_BRANCH;
          OP_J:           state_next_s = S_JUMP;
          default:        state_next_s = INV_NEXT;
        endcase
      end
      S_R_EXEC: begin
        bus.ula_src_a     = 1'b1;
        bus.ula_op        = r_ula_op(bus.funct);
        bus.alu_out_write = 1'b1;
        if (EXC_EN && bus.ula_overflow && is_add_sub(bus.funct)) begin
          state_next_s = S_EXC_EPC;
        end else begin
          state_next_s = S_R_WB;
        end
      end
      S_R_WB: begin
        bus.reg_dst   = 1'b1;
        bus.reg_write = 1'b1;
        state_next_s  = S_FETCH;
      end
      S_ADDI_EXEC, S_MEM_ADDR: begin
        bus.ula_src_a     = 1'b1;
        bus.ula_src_b     = SRCB_SEXT;
        bus.ula_op        = ULA_ADD;
        bus.alu_out_write = 1'b1;
        if (state_r == S_MEM_ADDR) begin
          state_next_s = (bus.opcode == OP_LW) ? S_LW_READ : S_SW_WRITE;
        end else if (EXC_EN && bus.ula_overflow) begin
          state_next_s = S_EXC_EPC;
        end else begin
          state_next_s = S_ADDI_WB;
        end
      end
      S_ADDI_WB: begin
        bus.reg_write = 1'b1;
        state_next_s  = S_FETCH;
      end
      S_LW_READ: begin
        bus.iord = 1'b1;
        if (NO_WAIT) begin
          bus.mdr_write = 1'b1;
          state_next_s  = S_LW_WB;
        end else begin
          state_next_s  = S_LW_WAIT;
        end
      end
      S_LW_WAIT: begin
        if (wait_done_s) begin
          bus.mdr_write = 1'b1;
          state_next_s  = S_LW_WB;
        end else begin
          state_next_s  = S_LW_WAIT;
        end
      end
      S_LW_WB: begin
        bus.mem_to_reg = 1'b1;
        bus.reg_write  = 1'b1;
        state_next_s   = S_FETCH;
      end
      S_SW_WRITE: begin
        bus.iord     = 1'b1;
        bus.mem_wr   = 1'b1;
        state_next_s = S_FETCH;
      end
      S_BRANCH: begin
        bus.ula_src_a = 1'b1;
        bus.ula_op    = ULA_SUB;
        bus.pc_source = PCSRC_ALUOUT;
        bus.pc_write  = (bus.opcode == OP_BEQ) ? bus.ula_zero : ~bus.ula_zero;
        state_next_s  = S_FETCH;
      end
      S_JUMP: begin
        bus.pc_source = PCSRC_JUMP;
        bus.pc_write  = 1'b1;
        state_next_s  = S_FETCH;
      end
      S_EXC_EPC: begin
        bus.ula_src_b = SRCB_FOUR;
        bus.ula_op    = ULA_SUB;
        state_next_s  = S_EXC_JUMP;
      end
      S_EXC_JUMP: begin
        bus.pc_source = PCSRC_EXC;
        bus.pc_write  = 1'b1;
        state_next_s  = S_FETCH;
      end
      S_HALT: begin
        state_next_s = S_HALT;
      end
      default: begin
        state_next_s = S_RESET;
      end
    endcase
  end

`ifdef CONTROLE_EXC_EN
  logic [1:0] cause_r;

  // Capture the cause on entry: from DECODE it is a bad opcode/funct, else overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      cause_r <= CAUSE_INV;
    end else if ((state_r != S_EXC_EPC) && (state_next_s == S_EXC_EPC)) begin
      cause_r <= (state_r == S_DECODE) ? CAUSE_INV : CAUSE_OVF;
    end else begin
      cause_r <= cause_r;
    end
  end

  assign bus.epc_write   = (state_r == S_EXC_EPC);
  assign bus.cause_write = (state_r == S_EXC_EPC);
  assign bus.cause       = (state_r == S_EXC_EPC) ? cause_r : CAUSE_INV;
`else
  assign bus.epc_write   = 1'b0;
  assign bus.cause_write = 1'b0;
  assign bus.cause       = 2'b00;
`endif

endmodule

// File: tb/tb_controle_multiciclo_exc.sv
// Scoreboard bench: two controllers (MEM_WAIT=1 and MEM_WAIT=3) driven with
// directed instruction sequences; expected per-cycle controls are queued.
module tb_controle_multiciclo_exc;

  typedef struct packed {
    logic       rst_out;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_wr;
    logic       ir_write;
    logic       mdr_write;
    logic       a_write;
    logic       b_write;
    logic       alu_out_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       ula_src_a;
    logic [1:0] ula_src_b;
    logic [2:0] ula_op;
    logic       epc_write;
    logic       cause_write;
    logic [1:0] cause;
  } ctl_t;

  typedef struct packed {
    logic [4:0] st;
    ctl_t       c;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1 = 1'b1;
  logic       rst3 = 1'b1;
  logic [5:0] opc_v = 6'h00;
  logic [5:0] fn_v = 6'h00;
  logic       z_v = 1'b0;
  logic       ov_v = 1'b0;

  controle_multiciclo_exc_if #(.STATE_W(5)) if1 ();
  controle_multiciclo_exc_if #(.STATE_W(5)) if3 ();

  assign if1.opcode = opc_v;
  assign if1.funct = fn_v;
  assign if1.ula_zero = z_v;
  assign if1.ula_overflow = ov_v;
  assign if3.opcode = opc_v;
  assign if3.funct = fn_v;
  assign if3.ula_zero = z_v;
  assign if3.ula_overflow = ov_v;

  controle_multiciclo_exc #(.MEM_WAIT(1), .STATE_W(5)) dut1 (.clk(clk), .reset(rst1), .bus(if1));
  controle_multiciclo_exc #(.MEM_WAIT(3), .STATE_W(5)) dut3 (.clk(clk), .reset(rst3), .bus(if3));

  ctl_t act1, act3;
  assign act1 = {if1.rst_out, if1.pc_write, if1.pc_source, if1.iord, if1.mem_wr, if1.ir_write,
                 if1.mdr_write, if1.a_write, if1.b_write, if1.alu_out_write, if1.reg_dst,
                 if1.mem_to_reg, if1.reg_write, if1.ula_src_a, if1.ula_src_b, if1.ula_op,
                 if1.epc_write, if1.cause_write, if1.cause};
  assign act3 = {if3.rst_out, if3.pc_write, if3.pc_source, if3.iord, if3.mem_wr, if3.ir_write,
                 if3.mdr_write, if3.a_write, if3.b_write, if3.alu_out_write, if3.reg_dst,
                 if3.mem_to_reg, if3.reg_write, if3.ula_src_a, if3.ula_src_b, if3.ula_op,
                 if3.epc_write, if3.cause_write, if3.cause};

  exp_t  q1[$];
  exp_t  q3[$];
  string n1[$];
  string n3[$];
  int    tests_run = 0;
  int    fails = 0;
  int    sel = 0;

  logic       cur_rst = 1'b1;
  logic [5:0] cur_opc = 6'h00;
  logic [5:0] cur_fn = 6'h00;
  logic       cur_z = 1'b0;
  logic       cur_ov = 1'b0;

  // Expected control word for a state, written out from the control table.
  function automatic ctl_t exp_ctl(input int s, input bit fin, input bit take,
                                   input logic [2:0] rop, input logic [1:0] cs);
    ctl_t c;
    c = '0;
    case (s)
      0: c.rst_out = 1'b1;
      2: if (fin) begin
           c.ir_write = 1'b1; c.pc_write = 1'b1; c.ula_src_b = 2'b01; c.ula_op = 3'b001;
         end
      3: begin
           c.a_write = 1'b1; c.b_write = 1'b1; c.alu_out_write = 1'b1;
           c.ula_src_b = 2'b11; c.ula_op = 3'b001;
         end
      4: begin c.ula_src_a = 1'b1; c.ula_op = rop; c.alu_out_write = 1'b1; end
      5: begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      6, 8: begin
           c.ula_src_a = 1'b1; c.ula_src_b = 2'b10; c.ula_op = 3'b001; c.alu_out_write = 1'b1;
         end
      7: c.reg_write = 1'b1;
      9: c.iord = 1'b1;
      10: c.mdr_write = fin;
      11: begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      12: begin c.iord = 1'b1; c.mem_wr = 1'b1; end
      13: begin
           c.ula_src_a = 1'b1; c.ula_op = 3'b010; c.pc_source = 2'b01; c.pc_write = take;
         end
      14: begin c.pc_source = 2'b10; c.pc_write = 1'b1; end
      15: begin
           c.ula_src_b = 2'b01; c.ula_op = 3'b010;
           c.epc_write = 1'b1; c.cause_write = 1'b1; c.cause = cs;
         end
      16: begin c.pc_source = 2'b11; c.pc_write = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // One cycle: apply the current inputs and queue what the selected DUT must show.
  task automatic step(input string nm, input int s, input bit fin = 1'b0, input bit take = 1'b0,
                      input logic [2:0] rop = 3'b000, input logic [1:0] cs = 2'b00);
    exp_t e;
    @(posedge clk);
    #1;
    rst1  = (sel == 0) ? cur_rst : 1'b1;
    rst3  = (sel == 1) ? cur_rst : 1'b1;
    opc_v = cur_opc;
    fn_v  = cur_fn;
    z_v   = cur_z;
    ov_v  = cur_ov;
    e.st  = 5'(s);
    e.c   = exp_ctl(s, fin, take, rop, cs);
    if (sel == 0) begin
      q1.push_back(e);
      n1.push_back(nm);
    end else begin
      q3.push_back(e);
      n3.push_back(nm);
    end
  endtask

  task automatic fetch_dec(input logic [5:0] opc, input logic [5:0] fn);
    int mw;
    mw = (sel == 0) ? 1 : 3;
    cur_opc = opc;
    cur_fn  = fn;
    cur_z   = 1'b0;
    cur_ov  = 1'b0;
    step("fetch", 1);
    for (int i = 1; i < mw; i++) step("fetch_wait", 2, 1'b0);
    step("fetch_ir", 2, 1'b1);
    step("decode", 3);
  endtask

  task automatic chk(input string nm, input exp_t e, input logic [4:0] st, input ctl_t a);
    tests_run++;
    if ({st, a} !== {e.st, e.c}) begin
      fails++;
      $display("FAIL %s: estado=%0d ctl=%h, expected estado=%0d ctl=%h", nm, st, a, e.st, e.c);
    end
  endtask

  // Monitor: compare each DUT against its queue on the falling edge.
  always @(negedge clk) begin
    if (q1.size() > 0) chk(n1.pop_front(), q1.pop_front(), if1.estado, act1);
    if (q3.size() > 0) chk(n3.pop_front(), q3.pop_front(), if3.estado, act3);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    // ---- MEM_WAIT=1 controller ----
    sel = 0;
    cur_rst = 1'b1;
    repeat (3) step("reset", 0);
    cur_rst = 1'b0;
    step("rst_out_pulse", 0);
    fetch_dec(6'h00, 6'h20);
    step("r_exec_add", 4, 1'b0, 1'b0, 3'b001);
    step("r_wb_add", 5);
    fetch_dec(6'h05, 6'h00);
    cur_z = 1'b0;
    step("bne_taken", 13, 1'b0, 1'b1);
    fetch_dec(6'h05, 6'h00);
    cur_z = 1'b1;
    step("bne_not_taken", 13, 1'b0, 1'b0);
    fetch_dec(6'h04, 6'h00);
    cur_z = 1'b1;
    step("beq_taken", 13, 1'b0, 1'b1);
    fetch_dec(6'h00, 6'h26);
    step("r_exec_xor", 4, 1'b0, 1'b0, 3'b110);
    step("r_wb_xor", 5);
    fetch_dec(6'h00, 6'h24);
    step("r_exec_and", 4, 1'b0, 1'b0, 3'b011);
    step("r_wb_and", 5);
    fetch_dec(6'h08, 6'h00);
    cur_ov = 1'b1;
    step("addi_exec_ovf", 6);
    cur_ov = 1'b0;
`ifdef CONTROLE_EXC_EN
    step("exc_epc_addi", 15, 1'b0, 1'b0, 3'b000, 2'b01);
    step("exc_jump_addi", 16);
`else
    step("addi_wb_ovf_ignored", 7);
`endif
    fetch_dec(6'h3F, 6'h00);
`ifdef CONTROLE_EXC_EN
    step("exc_epc_bad_op", 15, 1'b0, 1'b0, 3'b000, 2'b00);
    step("exc_jump_bad_op", 16);
`endif
    fetch_dec(6'h00, 6'h22);
    cur_ov = 1'b1;
    step("r_exec_sub_ovf", 4, 1'b0, 1'b0, 3'b010);
    cur_ov = 1'b0;
`ifdef CONTROLE_EXC_EN
    step("exc_epc_sub", 15, 1'b0, 1'b0, 3'b000, 2'b01);
    step("exc_jump_sub", 16);
`else
    step("r_wb_sub_ovf_ignored", 5);
`endif
    fetch_dec(6'h00, 6'h3F);
`ifdef CONTROLE_EXC_EN
    step("exc_epc_bad_funct", 15, 1'b0, 1'b0, 3'b000, 2'b00);
    step("exc_jump_bad_funct", 16);
`endif
    fetch_dec(6'h02, 6'h00);
    step("jump", 14);
    fetch_dec(6'h2B, 6'h00);
    step("sw_addr", 8);
    step("sw_write", 12);
    fetch_dec(6'h08, 6'h00);
    step("addi_exec", 6);
    step("addi_wb", 7);
    fetch_dec(6'h00, 6'h0D);
    repeat (3) step("halt", 17);
    cur_rst = 1'b1;
    step("halt_last", 17);
    step("halt_reset", 0);
    cur_rst = 1'b0;
    step("halt_release", 0);
    step("refetch", 1);

    // ---- MEM_WAIT=3 controller ----
    sel = 1;
    cur_rst = 1'b1;
    repeat (2) step("reset3", 0);
    cur_rst = 1'b0;
    step("rst_out_pulse3", 0);
    fetch_dec(6'h23, 6'h00);
    step("lw_addr", 8);
    step("lw_read", 9);
    step("lw_wait1", 10, 1'b0);
    step("lw_wait2", 10, 1'b0);
    step("lw_wait3_mdr", 10, 1'b1);
    step("lw_wb", 11);
    fetch_dec(6'h23, 6'h00);
    step("lw_addr_b", 8);
    step("lw_read_b", 9);
    step("lw_wait1_b", 10, 1'b0);
    cur_rst = 1'b1;
    step("lw_wait2_rst", 10, 1'b0);
    step("lw_abort", 0);
    cur_rst = 1'b0;
    step("abort_release", 0);
    step("abort_fetch", 1);

    for (int i = 0; i < 4; i++) begin
      if ((q1.size() + q3.size()) != 0) begin
        @(negedge clk);
        #1;
      end
    end
    tests_run++;
    if ((q1.size() + q3.size()) != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", q1.size() + q3.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
